alu_sequencer: RTL and testbench

//  Instruction-side driver for the datapath ALU. Accepts one R-format ALU instruction per

---
 rtl/alu_sequencer.sv | 111 +++++++++++
 tb/tb_alu_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches R-format operands, drives the ALU and issues GPR or LO/HI writeback beats
module alu_sequencer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int OP_W   = 5,
  parameter int MAX_OP = 13
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                ir_valid,
  output logic                ir_ready,
  input  logic [31:0]         ir,
  output logic [REG_AW-1:0]   rf_rd_addr,
  input  logic [DATA_W-1:0]   rf_rd_data,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  input  logic [2*DATA_W-1:0] alu_c,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [1:0]          wb_sel,
  output logic [REG_AW-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic                busy,
  output logic                illegal
);
  typedef enum logic [2:0] {IDLE, RDB, RDC, LDB, EXEC, WB1, WB2} state_t;
  localparam logic [4:0] MAX_OP_V = 5'(MAX_OP);
  state_t state_q, state_d;
  logic [31:15] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic [OP_W-1:0] op_q, op_d;
  logic illegal_q, illegal_d;
  logic [4:0] cur_op;
  logic accept, bad_op, unary, muldiv;
  assign cur_op = ir_q[31:27];
  assign accept = ir_valid && state_q == IDLE;
  assign bad_op = ir[31:27] > MAX_OP_V;
  assign unary  = cur_op == 5'd4 || cur_op == 5'd12 || cur_op == 5'd13;
  assign muldiv = cur_op == 5'd10 || cur_op == 5'd11;
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    op_d      = op_q;
    illegal_d = accept && bad_op;
    case (state_q)
      IDLE: if (accept) begin
        ir_d = ir[31:15];
        if (!bad_op) begin
          state_d = RDB;
          a_d     = '0;
          b_d     = '0;
          op_d    = OP_W'(ir[31:27]);
        end
      end
      RDB:  state_d = RDC;
      RDC: begin
        state_d = unary ? EXEC : LDB;
        a_d     = unary ? a_q : rf_rd_data;
        b_d     = unary ? rf_rd_data : b_q;
      end
      LDB: begin
        b_d     = rf_rd_data;
        state_d = EXEC;
      end
      EXEC: begin
        z_d     = alu_c;
        state_d = WB1;
      end
      WB1:  state_d = wb_ready ? (muldiv ? WB2 : IDLE) : WB1;
      WB2:  state_d = wb_ready ? IDLE : WB2;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      z_q       <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      z_q       <= z_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end
  assign ir_ready   = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign illegal    = illegal_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rf_rd_addr = state_q == RDB ? REG_AW'(ir_q[22:19]) :
                      (state_q == RDC && !unary) ? REG_AW'(ir_q[18:15]) : '0;
  assign wb_valid   = state_q == WB1 || state_q == WB2;
  assign wb_sel     = state_q == WB2 ? 2'b10 : (state_q == WB1 && muldiv) ? 2'b01 : 2'b00;
  assign wb_addr    = (state_q == WB1 && !muldiv) ? REG_AW'(ir_q[26:23]) : '0;
  assign wb_data    = state_q == WB1 ? z_q[DATA_W-1:0] :
                      state_q == WB2 ? z_q[2*DATA_W-1:DATA_W] : '0;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random instructions checked against a register-file/ALU reference model
module tb_alu_sequencer;
  logic clock = 0, clear = 0, ir_valid = 0, wb_ready = 0, perturb = 0;
  logic [31:0] ir = 0;
  logic [3:0] rf_rd_addr, wb_addr;
  logic [31:0] rf_rd_data = 0, alu_a, alu_b, wb_data;
  logic [4:0] alu_op;
  logic [63:0] alu_c;
  logic ir_ready, wb_valid, busy, illegal;
  logic [1:0] wb_sel;
  logic [31:0] rf [16];
  int n_cmp = 0, n_bad = 0;

  alu_sequencer dut (
    .clock(clock), .clear(clear), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_c(alu_c), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_sel(wb_sel), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .illegal(illegal)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      5'd0:  return {32'd0, a | b};
      5'd1:  return {32'd0, a & b};
      5'd2:  return {32'd0, a + b};
      5'd3:  return {32'd0, a - b};
      5'd4:  return {32'd0, -b};
      5'd5:  return {32'd0, a >> s};
      5'd6:  return {32'd0, a << s};
      5'd7:  return {32'd0, (a >> s) | (a << (6'd32 - 6'(s)))};
      5'd8:  return {32'd0, (a << s) | (a >> (6'd32 - 6'(s)))};
      5'd9:  return {32'd0, 32'($signed(a) >>> s)};
      5'd10: return {32'd0, a} * {32'd0, b};
      5'd11: return (b == 0) ? 64'd0 : {a % b, a / b};
      5'd12: return {32'd0, b + 32'd1};
      5'd13: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  // The external ALU; perturb scrambles it to prove the captured result is not resampled.
  assign alu_c = perturb ? ~alu_f(alu_op, alu_a, alu_b) : alu_f(alu_op, alu_a, alu_b);

  always @(posedge clock) rf_rd_data <= rf[rf_rd_addr];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {ir_ready, busy, illegal, wb_valid, wb_sel, wb_addr, rf_rd_addr, alu_op}, {1'b1, 18'd0});
    chk({tag, "_data"}, {wb_data, alu_a}, 64'd0);
    chk({tag, "_b"}, alu_b, 32'd0);
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    ir = {op, ra, rb, rc, 15'($urandom)};
    ir_valid = 1;
    @(posedge clock);
    #1 ir_valid = 0;
  endtask

  task automatic do_illegal(input logic [4:0] op, input logic [3:0] rb);
    chk("ill_ready_before", ir_ready, 1'b1);
    issue(op, 4'($urandom), rb, 4'($urandom));
    @(negedge clock);
    chk("ill_pulse", {illegal, ir_ready, busy, wb_valid}, 4'b1100);
    chk("ill_noread", rf_rd_addr == rb, 1'b0);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rc, input int max_stall);
    logic unary, md, held, ill;
    logic [31:0] a, b;
    logic [63:0] res;
    logic [37:0] expb [2];
    logic [37:0] prev, cur;
    int nb, lat, cyc, beat, hits, stall, first;
    unary = op == 5'd4 || op == 5'd12 || op == 5'd13;
    md = op == 5'd10 || op == 5'd11;
    a = unary ? 32'd0 : rf[rb];
    b = unary ? rf[rb] : rf[rc];
    res = alu_f(op, a, b);
    nb = md ? 2 : 1;
    lat = unary ? 4 : 5;
    expb[0] = md ? {2'b01, 4'd0, res[31:0]} : {2'b00, ra, res[31:0]};
    expb[1] = {2'b10, 4'd0, res[63:32]};
    chk("ready_before", ir_ready, 1'b1);
    wb_ready = 1'($urandom);
    issue(op, ra, rb, rc);
    ir = $urandom;
    cyc = 0; beat = 0; hits = 0; held = 0; ill = 0; first = -1; stall = max_stall; prev = '0;
    while (beat < nb && cyc < 60) begin
      @(negedge clock);
      cyc++;
      ill |= illegal;
      if (rf_rd_addr == rb) hits++;
      chk("busy_not_ready", {ir_ready, busy}, 2'b01);
      if (cyc == 1) chk("rd_rb", rf_rd_addr, rb);
      if (cyc == 2 && !unary) chk("rd_rc", rf_rd_addr, rc);
      if (cyc == lat - 1) chk("exec_operands", {alu_op, alu_a, alu_b}, {op, a, b});
      if (held) chk("hold_valid", wb_valid, 1'b1);
      if (wb_valid) begin
        perturb = 1;
        cur = {wb_sel, wb_addr, wb_data};
        if (first < 0) begin
          first = cyc;
          chk("latency", cyc, lat);
        end
        if (held) chk("hold_stable", cur, prev);
        chk(beat == 0 ? "beat1" : "beat2", cur, expb[beat]);
        prev = cur;
        if (stall > 0) begin
          wb_ready = 0;
          stall--;
          held = 1;
        end else begin
          wb_ready = 1;
          held = 0;
          beat++;
          stall = $urandom_range(0, max_stall);
        end
      end else wb_ready = 1'($urandom);
      ir_valid = 1'($urandom);
      ir = $urandom;
    end
    chk("beats_done", beat, nb);
    @(negedge clock);
    ir_valid = 0;
    perturb = 0;
    chk("idle_after", {ir_ready, busy, wb_valid}, 3'b100);
    chk("no_illegal", ill, 1'b0);
    if (unary && rb != 0) chk("unary_one_read", hits, 1);
    if (!md) rf[ra] = res[31:0];
  endtask

  initial begin
    logic [63:0] mres;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    repeat (3) @(negedge clock);
    chk_reset("reset_init");
    clear = 1;
    @(negedge clock);
    chk_reset("reset_release");
    rf[1] = 5; rf[2] = 7;
    run_instr(5'd2, 4'd3, 4'd1, 4'd2, 0);
    rf[4] = 32'h0001_0000; rf[5] = 32'h0001_0000;
    run_instr(5'd10, 4'd6, 4'd4, 4'd5, 0);
    rf[7] = 1;
    run_instr(5'd4, 4'd8, 4'd7, 4'd9, 0);
    rf[10] = 100; rf[11] = 7;
    run_instr(5'd11, 4'd0, 4'd10, 4'd11, 3);
    do_illegal(5'd14, 4'd3);
    run_instr(5'd2, 4'd12, 4'd3, 4'd3, 1);
    issue(5'd2, 4'd13, 4'd1, 4'd2);
    repeat (4) @(negedge clock);
    chk("exec_in_flight", {busy, alu_op}, {1'b1, 5'd2});
    clear = 0;
    #1 chk_reset("reset_exec");
    @(negedge clock);
    clear = 1;
    wb_ready = 0;
    mres = alu_f(5'd10, rf[4], rf[5]);
    issue(5'd10, 4'd0, 4'd4, 4'd5);
    repeat (5) @(negedge clock);
    chk("wb1_lo", {wb_valid, wb_sel, wb_data}, {1'b1, 2'b01, mres[31:0]});
    wb_ready = 1;
    @(negedge clock);
    wb_ready = 0;
    chk("wb2_hi", {wb_valid, wb_sel, wb_data}, {1'b1, 2'b10, mres[63:32]});
    clear = 0;
    #1 chk_reset("reset_wb2");
    @(negedge clock);
    clear = 1;
    wb_ready = 1;
    repeat (3) begin
      @(negedge clock);
      chk("no_partial_hi", {wb_valid, busy}, 2'b00);
    end
    run_instr(5'd2, 4'd14, 4'd1, 4'd2, 0);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) do_illegal(5'($urandom_range(14, 31)), 4'($urandom_range(1, 15)));
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 15)] = $urandom;
      run_instr(5'($urandom_range(0, 13)), 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
